// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes on both sides.
// Single-cycle ops: ADD, SUB, AND, OR, XOR, SLT, SLL (latency 1, throughput 1/cycle).
// Op 111 is an iterative shift-add multiply when ALU_SEQ_MUL_EN is defined; otherwise it is a
// single-cycle op returning zero and no multiply datapath or BUSY state exists.
module alu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ALUControl,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow,
  output logic             Busy
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpSlt = 3'b101;
  localparam logic [2:0] OpSll = 3'b110;
  localparam logic [2:0] OpMul = 3'b111;

  // Output register bank
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  // Single-cycle datapath results
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH-1:0] sc_res;
  logic             sc_carry;
  logic             sc_ovf;
  logic             slt_w;

  logic idle_w;
  logic accept_w;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic {StIdle, StBusy} state_e;

  localparam logic [SHW-1:0] LastIter = SHW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] mul_step;

  // One shift-add iteration: accumulate the multiplicand when the current multiplier bit is set
  assign mul_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign idle_w   = (state_q == StIdle);
  assign Busy     = (state_q == StBusy);
`else
  assign idle_w = 1'b1;
  assign Busy   = 1'b0;
`endif

  // A new op may enter in the same cycle the previous result is consumed
  assign InReady  = idle_w && (!out_valid_q || OutReady);
  assign accept_w = InValid && InReady;

  assign sum_w  = {1'b0, SrcA} + {1'b0, SrcB};
  assign diff_w = {1'b0, SrcA} - {1'b0, SrcB};
  assign slt_w  = $signed(SrcA) < $signed(SrcB);

  // Single-cycle op result plus carry/overflow
  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    unique case (ALUControl)
      OpAdd: begin
        sc_res   = sum_w[WIDTH-1:0];
        sc_carry = sum_w[WIDTH];
        sc_ovf   = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (sum_w[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OpSub: begin
        sc_res   = diff_w[WIDTH-1:0];
        sc_carry = diff_w[WIDTH]; // borrow: set iff A < B unsigned
        sc_ovf   = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (diff_w[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OpAnd: sc_res = SrcA & SrcB;
      OpOr:  sc_res = SrcA | SrcB;
      OpXor: sc_res = SrcA ^ SrcB;
      OpSlt: sc_res = {{(WIDTH-1){1'b0}}, slt_w};
      OpSll: sc_res = SrcA << SrcB[SHW-1:0];
      // Multiply is not a single-cycle op; without the multiplier it returns zero
      OpMul: sc_res = '0;
      default: sc_res = '0;
    endcase
  end

  // Next-state: output register, handshake and (optional) multiply sequencer
  always_comb begin
    res_d       = res_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
`ifdef ALU_SEQ_MUL_EN
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
`endif

    if (out_valid_q && OutReady) begin
      out_valid_d = 1'b0;
    end

`ifdef ALU_SEQ_MUL_EN
    if (state_q == StBusy) begin
      acc_d    = mul_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == LastIter) begin
        res_d       = mul_step;
        zero_d      = (mul_step == '0);
        neg_d       = mul_step[WIDTH-1];
        carry_d     = 1'b0;
        ovf_d       = 1'b0;
        out_valid_d = 1'b1;
        state_d     = StIdle;
      end
    end else if (accept_w) begin
      if (ALUControl == OpMul) begin
        state_d  = StBusy;
        acc_d    = '0;
        mcand_d  = SrcA;
        mplier_d = SrcB;
        cnt_d    = '0;
      end else begin
        res_d       = sc_res;
        zero_d      = (sc_res == '0);
        neg_d       = sc_res[WIDTH-1];
        carry_d     = sc_carry;
        ovf_d       = sc_ovf;
        out_valid_d = 1'b1;
      end
    end
`else
    if (accept_w) begin
      res_d       = sc_res;
      zero_d      = (sc_res == '0);
      neg_d       = sc_res[WIDTH-1];
      carry_d     = sc_carry;
      ovf_d       = sc_ovf;
      out_valid_d = 1'b1;
    end
`endif
  end

  // Output register bank; reset discards any result in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_q       <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      res_q       <= res_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef ALU_SEQ_MUL_EN
  // Multiply sequencer state; reset mid-multiply drops the partial product
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end
`endif

  assign OutValid  = out_valid_q;
  assign ALUResult = res_q;
  assign Zero      = zero_q;
  assign Negative  = neg_q;
  assign Carry     = carry_q;
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=32): vector table applied back-to-back, then hand-written
// back-pressure, op-111 and reset-recovery sequences.
module tb_alu_seq;

  localparam int unsigned W = 32;

  logic         clk;
  logic         reset_n;
  logic         InValid;
  logic         InReady;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic [2:0]   ALUControl;
  logic         OutValid;
  logic         OutReady;
  logic [W-1:0] ALUResult;
  logic         Zero;
  logic         Negative;
  logic         Carry;
  logic         Overflow;
  logic         Busy;

  int total;
  int bad;

  alu_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .InValid    (InValid),
    .InReady    (InReady),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUControl (ALUControl),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .ALUResult  (ALUResult),
    .Zero       (Zero),
    .Negative   (Negative),
    .Carry      (Carry),
    .Overflow   (Overflow),
    .Busy       (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         n;
    logic         c;
    logic         v;
  } vec_t;

  vec_t vecs[16];
  int   nvec;

  // Packs {result, Z, N, C, V, OutValid, Busy}
  function automatic logic [63:0] pack_out(logic [W-1:0] r, logic z, logic n, logic c,
                                           logic v, logic ov, logic bz);
    return {26'd0, r, z, n, c, v, ov, bz};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] dut_out();
    return pack_out(ALUResult, Zero, Negative, Carry, Overflow, OutValid, Busy);
  endfunction

  task automatic add_vec(input string nm, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] r, input logic z,
                         input logic n, input logic c, input logic v);
    vecs[nvec] = '{nm, op, a, b, r, z, n, c, v};
    nvec++;
  endtask

  initial begin
    int busy_cnt;
    total    = 0;
    bad      = 0;
    nvec     = 0;
    reset_n  = 1'b0;
    InValid  = 1'b0;
    OutReady = 1'b0;
    SrcA     = '0;
    SrcB     = '0;
    ALUControl = 3'b000;

    //      name        op      A             B             result        Z     N     C     V
    add_vec("add_ovf",  3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
    add_vec("sub_borr", 3'b001, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b1, 1'b0);
    add_vec("sub_zero", 3'b001, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec("xor",      3'b100, 32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec("slt_neg",  3'b101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec("sll_31",   3'b110, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec("add_carry",3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
    add_vec("sub_ovf",  3'b001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    add_vec("and",      3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec("or",       3'b011, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec("slt_pos",  3'b101, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec("sll_mask", 3'b110, 32'h00000003, 32'h00000024, 32'h00000030, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec("slt_min",  3'b101, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec("add_2ovf", 3'b000, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1);
`ifndef ALU_SEQ_MUL_EN
    add_vec("op7_zero", 3'b111, 32'h0000FFFF, 32'h00010001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_out", dut_out(), pack_out('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    chk("reset_inready", {63'd0, InReady}, 64'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // Table applied back-to-back: one accept per cycle, result checked one cycle later
    OutReady = 1'b1;
    for (int i = 0; i < nvec; i++) begin
      ALUControl = vecs[i].op;
      SrcA       = vecs[i].a;
      SrcB       = vecs[i].b;
      InValid    = 1'b1;
      #1;
      chk({vecs[i].name, "_inready"}, {63'd0, InReady}, 64'd1);
      @(negedge clk);
      chk(vecs[i].name, dut_out(),
          pack_out(vecs[i].res, vecs[i].z, vecs[i].n, vecs[i].c, vecs[i].v, 1'b1, 1'b0));
    end
    InValid = 1'b0;
    @(negedge clk);
    chk("drain_outvalid", {63'd0, OutValid}, 64'd0);

    // Back-pressure: AND held for 5 cycles while a second op waits
    OutReady   = 1'b0;
    ALUControl = 3'b010;
    SrcA       = 32'hF0F0F0F0;
    SrcB       = 32'hFF00FF00;
    InValid    = 1'b1;
    @(negedge clk);
    ALUControl = 3'b000;
    SrcA       = 32'd2;
    SrcB       = 32'd2;
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold", dut_out(), pack_out(32'hF000F000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
      chk("bp_inready", {63'd0, InReady}, 64'd0);
      @(negedge clk);
    end
    OutReady = 1'b1;
    #1;
    chk("bp_release_inready", {63'd0, InReady}, 64'd1);
    @(negedge clk);
    InValid = 1'b0;
    chk("bp_second", dut_out(), pack_out(32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    chk("bp_drain", {63'd0, OutValid}, 64'd0);

`ifdef ALU_SEQ_MUL_EN
    // Multiply: Busy for W cycles, result on the following sample
    ALUControl = 3'b111;
    SrcA       = 32'h0000FFFF;
    SrcB       = 32'h00010001;
    InValid    = 1'b1;
    @(negedge clk);
    InValid  = 1'b0;
    SrcA     = '0;
    SrcB     = '0;
    busy_cnt = 0;
    for (int k = 0; k < W; k++) begin
      if (Busy && !OutValid && !InReady) busy_cnt++;
      @(negedge clk);
    end
    chk("mul_busy_cycles", 64'(busy_cnt), 64'(W));
    chk("mul_result", dut_out(), pack_out(32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    chk("mul_drain", {63'd0, OutValid}, 64'd0);

    // Reset in the middle of a multiply
    ALUControl = 3'b111;
    SrcA       = 32'h12345678;
    SrcB       = 32'h9ABCDEF0;
    InValid    = 1'b1;
    @(negedge clk);
    InValid = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_mul_busy", {63'd0, Busy}, 64'd1);
    reset_n = 1'b0;
    #1;
`else
    // Reset while a result is held under back-pressure
    OutReady   = 1'b0;
    ALUControl = 3'b011;
    SrcA       = 32'h00000F00;
    SrcB       = 32'h0000000F;
    InValid    = 1'b1;
    @(negedge clk);
    InValid = 1'b0;
    chk("held_before_reset", dut_out(),
        pack_out(32'h00000F0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    reset_n = 1'b0;
    #1;
`endif
    chk("async_reset_out", {63'd0, Busy | OutValid}, 64'd0);
    chk("async_reset_inready", {63'd0, InReady}, 64'd1);
    @(negedge clk);
    reset_n  = 1'b1;
    OutReady = 1'b1;
    @(negedge clk);
    chk("post_reset_no_valid", {63'd0, OutValid}, 64'd0);
    ALUControl = 3'b000;
    SrcA       = 32'd2;
    SrcB       = 32'd2;
    InValid    = 1'b1;
    @(negedge clk);
    InValid = 1'b0;
    chk("post_reset_add", dut_out(), pack_out(32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    repeat (2) @(negedge clk);
    chk("post_reset_idle", {62'd0, OutValid, Busy}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

endmodule
